// File: rtl/pcg_rr_arbiter.sv
// pcg_rr_arbiter: round-robin arbiter that serves each grant with a byte drawn from a 16-bit LCG
// passed through a PCG-style xorshift/rotate output function.
module pcg_rr_arbiter #(
  parameter int          NREQ = 4,
  parameter logic [15:0] MULT = 16'h5851,
  parameter logic [15:0] INC  = 16'h1405
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            seed_load,
  input  logic [15:0]     seed,
  output logic [NREQ-1:0] grant,
  output logic            rnd_valid,
  output logic [7:0]      rnd_data,
  output logic            busy,
  output logic [7:0]      draw_cnt
);
  localparam int W = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, STEP, OUT} st_t;
  st_t         fsm;
  logic [15:0] state, lcg_next;
  logic [W-1:0] last_winner, winner, pick, cand;
  logic        found;
  logic [7:0]  xs, rnd;
  // first requesting index at or after last_winner+1, wrapping
  always_comb begin
    pick = '0;
    found = 1'b0;
    cand = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = W'((int'(last_winner) + i) % NREQ);
      if (!found && req[cand]) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
  assign lcg_next = state * MULT + INC;
  assign xs       = 8'(((state >> 2) ^ state) >> 3);
  assign rnd      = 8'({xs, xs} >> state[15:13]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= IDLE;
      state <= '0;
      last_winner <= W'(NREQ - 1);
      winner <= '0;
      grant <= '0;
      rnd_valid <= 1'b0;
      rnd_data <= '0;
      busy <= 1'b0;
      draw_cnt <= '0;
    end else begin
      grant <= '0;
      rnd_valid <= 1'b0;
      rnd_data <= '0;
      if (seed_load) begin
        state <= seed;
        fsm <= IDLE;
        busy <= 1'b0;
      end else begin
        case (fsm)
          IDLE: if (found) begin
            winner <= pick;
            fsm <= STEP;
            busy <= 1'b1;
          end
          STEP: begin
            state <= lcg_next;
            fsm <= OUT;
          end
          OUT: begin
            grant <= NREQ'(1) << winner;
            rnd_valid <= 1'b1;
            rnd_data <= rnd;
            draw_cnt <= draw_cnt + 8'd1;
            last_winner <= winner;
            fsm <= IDLE;
            busy <= 1'b0;
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pcg_rr_arbiter.sv
// tb_pcg_rr_arbiter: directed stimulus pushes expected grants into a scoreboard; a negedge monitor pops and compares.
module tb_pcg_rr_arbiter;
  logic        clk = 1'b0, rst = 1'b1, seed_load = 1'b0;
  logic [3:0]  req = '0, grant;
  logic [15:0] seed = '0;
  logic        rnd_valid, busy;
  logic [7:0]  rnd_data, draw_cnt;
  int          cyc = 0, n_chk = 0, n_pass = 0;
  typedef struct {logic [3:0] g; logic [7:0] d; logic [7:0] c; int cy;} exp_t;
  exp_t        sb[$];
  pcg_rr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed(seed),
    .grant(grant), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .busy(busy), .draw_cnt(draw_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req_v, cyc);
  endtask
  function automatic logic [15:0] m_lcg(input logic [15:0] s);
    return s * 16'h5851 + 16'h1405;
  endfunction
  function automatic logic [7:0] m_f(input logic [15:0] s);
    logic [15:0] t;
    logic [7:0]  x;
    logic [2:0]  r;
    t = (s >> 2) ^ s;
    x = t[10:3];
    r = s[15:13];
    return (x >> r) | (x << (4'd8 - {1'b0, r}));
  endfunction
  task automatic push(input logic [3:0] g, input logic [7:0] d, input logic [7:0] c, input int cy);
    exp_t e;
    e.g = g; e.d = d; e.c = c; e.cy = cy;
    sb.push_back(e);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_grant"}, 32'(grant), 0);
    chk({nm, "_valid"}, 32'(rnd_valid), 0);
    chk({nm, "_data"}, 32'(rnd_data), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_cnt"}, 32'(draw_cnt), 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    chk("valid_vs_grant", 32'(rnd_valid), 32'(grant != 0));
    if (grant != 0 || rnd_valid) begin
      chk("onehot", 32'($onehot(grant)), 1);
      if (sb.size() == 0) chk("unexpected_grant", 32'(grant), 0);
      else begin
        e = sb.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("rnd_data", 32'(rnd_data), 32'(e.d));
        chk("draw_cnt", 32'(draw_cnt), 32'(e.c));
        chk("grant_cycle", 32'(cyc), 32'(e.cy));
      end
    end else chk("idle_data", 32'(rnd_data), 0);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] s;
    tick(2);
    chk_zero("reset");
    rst = 1'b0;
    // single requester held: two draws with hand-computed bytes
    req = 4'b0001;
    push(4'b0001, 8'h20, 8'd1, cyc + 3);
    push(4'b0001, 8'h9F, 8'd2, cyc + 6);
    tick(6);
    req = '0;
    tick(2);
    // all requesters: rotation 0,1,2,3,0
    rst_pulse();
    req = 4'b1111;
    s = '0;
    for (int i = 0; i < 5; i++) begin
      s = m_lcg(s);
      push(4'(1 << (i % 4)), m_f(s), 8'(i + 1), cyc + 3 * (i + 1));
    end
    tick(15);
    req = '0;
    tick(2);
    // seed load colliding with a request in IDLE
    rst_pulse();
    seed_load = 1'b1;
    seed = 16'h0000;
    req = 4'b0001;
    push(4'b0001, 8'h20, 8'd1, cyc + 4);
    tick(1);
    seed_load = 1'b0;
    tick(3);
    req = 4'b0010;
    tick(1);
    chk("busy_step", 32'(busy), 1);
    // seed load during STEP drops the draw
    seed_load = 1'b1;
    seed = 16'h1234;
    tick(1);
    chk("busy_after_seed", 32'(busy), 0);
    seed_load = 1'b0;
    push(4'b0010, m_f(m_lcg(16'h1234)), 8'd2, cyc + 3);
    tick(3);
    req = '0;
    tick(2);
    // async reset mid-draw
    rst_pulse();
    req = 4'b0001;
    tick(1);
    chk("busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    tick(2);
    rst = 1'b0;
    push(4'b0001, 8'h20, 8'd1, cyc + 3);
    tick(3);
    req = '0;
    tick(2);
    // 256 draws: counter wraps to 0
    rst_pulse();
    req = 4'b0001;
    s = '0;
    for (int i = 0; i < 256; i++) begin
      s = m_lcg(s);
      push(4'b0001, m_f(s), 8'(i + 1), cyc + 3 * (i + 1));
    end
    tick(768);
    req = '0;
    tick(4);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pcg_rr_arbiter.md
PCG_RR_ARBITER -- requirements
Module: pcg_rr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 SHALL have parameter MULT, default 16'h5851, LCG multiplier.
REQ-003 SHALL have parameter INC, default 16'h1405, LCG increment.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-006 SHALL have port req  input  4  per-requester draw request, level, held until granted.
REQ-007 SHALL have port seed_load  input  1  load seed into generator state.
REQ-008 SHALL have port seed  input  16  seed value.
REQ-009 SHALL have port grant  output  4  one-hot, one-cycle pulse marking the served requester.
REQ-010 SHALL have port rnd_valid  output  1  high exactly when grant is non-zero.
REQ-011 SHALL have port rnd_data  output  8  random byte, valid while rnd_valid is high, else 0.
REQ-012 SHALL have port busy  output  1  high in STEP and OUT states.
REQ-013 SHALL have port draw_cnt  output  8  count of completed grants, wraps 255->0.

Function
REQ-014 SHALL implement FSM states IDLE, STEP, OUT; every output is registered.
REQ-015 IDLE: if seed_load=0 and req!=0, SHALL latch the round-robin winner and go to STEP; else stay.
REQ-016 Round robin SHALL search from (last_winner+1) mod 4 upward; last_winner updates only on grant.
REQ-017 STEP: SHALL update state <= state*MULT + INC, truncated to 16 bits; next state OUT.
REQ-018 OUT: SHALL assert grant[winner], rnd_valid=1, rnd_data = f(state) for exactly one cycle; next state IDLE.
REQ-019 f(s): xs = bits[7:0] of (((s>>2) XOR s) >> 3); r = s[15:13]; result = xs rotated right by r (8-bit rotate, r=0 gives xs).
REQ-020 Latency: req sampled high in IDLE at edge n -> grant visible after edge n+2; one draw per 3 cycles maximum.
REQ-021 req changes while busy SHALL be ignored; winner is fixed once latched.
REQ-022 A requester still holding req after its grant SHALL be eligible again only after the other pending requesters in rotation order.
REQ-023 seed_load=1 in any state SHALL set state <= seed, return FSM to IDLE, and suppress any grant for that cycle; in-flight draw is dropped; draw_cnt unchanged.
REQ-024 seed_load and req both high in IDLE: seed load wins; request served from next cycle.
REQ-025 draw_cnt SHALL increment on each OUT cycle, wrapping 8'hFF -> 8'h00.
REQ-026 seed=16'h0000 SHALL be legal; no lock-up state exists (INC odd).

Reset
REQ-027 rst high SHALL immediately force: FSM IDLE, state 16'h0000, last_winner 3 (req[0] highest priority first), grant 0, rnd_valid 0, rnd_data 0, busy 0, draw_cnt 0.
REQ-028 rst asserted mid-draw SHALL cancel it with no grant emitted; outputs return to reset values without waiting for clk.
REQ-029 After rst deassertion the first rising edge SHALL already evaluate IDLE normally.

Verification
REQ-030 Reset, req=4'b0001 -> grant=0001, rnd_valid=1, rnd_data=8'h20 two edges later; internal state 16'h1405; draw_cnt=1.
REQ-031 Continue holding req=0001 -> next grant 3 cycles later, state 16'h219A, rnd_data=8'h9F; draw_cnt=2.
REQ-032 Reset, req=4'b1111 held -> grants 0001,0010,0100,1000,0001 at 3-cycle spacing, never two bits set.
REQ-033 Reset, assert seed_load with seed=16'h0000 and req=0001 same cycle -> no grant that cycle; grant with 8'h20 three edges later.
REQ-034 req=0001, assert rst during STEP -> grant never pulses, all outputs 0 asynchronously; after release, same req yields 8'h20 again.
REQ-035 256 consecutive draws -> draw_cnt wraps to 8'h00 on the 256th grant.
